// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch and data ports, data wins; optional MEM_ARB_TIMEOUT_EN abort
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_sel_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o,
  output logic              timeout_err_o
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, DRAIN} state_t;
  state_t state;
  logic abort, done;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (state == IDLE || (state == IF_BUSY && flush_i)) ? '0 : cnt + 1'b1;
  assign abort = state != IDLE && cnt == CW'(TIMEOUT_CYC - 1);
`else
  assign abort = 1'b0;
`endif
  assign done = bus_ack_i | abort;
  assign timeout_err_o = abort;
  assign if_ack_o = state == IF_BUSY && !flush_i && done;
  assign d_ack_o = state == D_BUSY && done;
  assign if_rdata_o = (if_ack_o && bus_ack_i) ? bus_rdata_i : '0;
  assign d_rdata_o = (d_ack_o && bus_ack_i) ? bus_rdata_i : '0;
  assign stallreq_if_o = if_req_i & ~if_ack_o;
  assign stallreq_mem_o = d_req_i & ~d_ack_o;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus_req_o <= 1'b0;
      bus_we_o <= 1'b0;
      bus_sel_o <= '0;
      bus_addr_o <= '0;
      bus_wdata_o <= '0;
    end else if (state == IDLE) begin
      if (d_req_i) begin
        state <= D_BUSY;
        bus_req_o <= 1'b1;
        bus_we_o <= d_we_i;
        bus_sel_o <= d_sel_i;
        bus_addr_o <= d_addr_i;
        bus_wdata_o <= d_wdata_i;
      end else if (if_req_i && !flush_i) begin
        state <= IF_BUSY;
        bus_req_o <= 1'b1;
        bus_we_o <= 1'b0;
        bus_sel_o <= 4'hF;
        bus_addr_o <= if_addr_i;
        bus_wdata_o <= '0;
      end
    end else if (done) begin
      state <= IDLE;
      bus_req_o <= 1'b0;
    end else if (state == IF_BUSY && flush_i) state <= DRAIN;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic clk = 0, rst = 1;
  logic if_req = 0, if_ack, d_req = 0, d_we = 0, d_ack, flush = 0;
  logic [31:0] if_addr = 0, if_rdata, d_addr = 0, d_wdata = 0, d_rdata;
  logic [3:0] d_sel = 0, bus_sel;
  logic bus_req, bus_we, bus_ack = 0, st_if, st_mem, terr;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = 0;
  int checks = 0, failures = 0;
  logic p_req = 0, p_ack = 0;
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .d_req_i(d_req), .d_we_i(d_we), .d_sel_i(d_sel), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack), .flush_i(flush), .bus_req_o(bus_req), .bus_we_o(bus_we),
    .bus_sel_o(bus_sel), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata),
    .bus_ack_i(bus_ack), .stallreq_if_o(st_if), .stallreq_mem_o(st_mem), .timeout_err_o(terr)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (rst) begin
      p_req <= 1'b0;
      p_ack <= 1'b0;
    end else begin
      if (p_req && !p_ack && !d_req) $error("d_req dropped before d_ack");
      p_req <= d_req;
      p_ack <= d_ack;
    end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata} !== 70'd0) begin failures++; $display("FAIL reset_bus got=%h exp=0", {bus_req, bus_we, bus_sel, bus_addr, bus_wdata}); end
    checks++; if ({if_ack, d_ack, terr, st_if, st_mem} !== 5'd0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {if_ack, d_ack, terr, st_if, st_mem}); end
    cyc;
    rst = 0;
  endtask
  task automatic test_fetch;
    cyc;
    if_req = 1; if_addr = 32'h100;
    #2;
    checks++; if ({bus_req, st_if} !== 2'b01) begin failures++; $display("FAIL fetch_req_n got=%b exp=01", {bus_req, st_if}); end
    cyc;
    #2;
    checks++; if ({bus_req, bus_we, bus_sel, bus_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin failures++; $display("FAIL fetch_grant got=%h exp=%h", {bus_req, bus_we, bus_sel, bus_addr}, {1'b1, 1'b0, 4'hF, 32'h100}); end
    for (int i = 0; i < 2; i++) begin
      cyc;
      #2;
      checks++; if ({bus_req, st_if, if_ack} !== 3'b110) begin failures++; $display("FAIL fetch_wait%0d got=%b exp=110", i, {bus_req, st_if, if_ack}); end
    end
    cyc;
    bus_ack = 1; bus_rdata = 32'h3C01_0001;
    #2;
    checks++; if ({if_ack, st_if, d_ack, terr} !== 4'b1000) begin failures++; $display("FAIL fetch_ack got=%b exp=1000", {if_ack, st_if, d_ack, terr}); end
    checks++; if (if_rdata !== 32'h3C01_0001 || d_rdata !== 32'h0) begin failures++; $display("FAIL fetch_rdata got=%h/%h exp=3c010001/0", if_rdata, d_rdata); end
    cyc;
    bus_ack = 0; if_req = 0;
    #2;
    checks++; if ({bus_req, if_ack} !== 2'b00) begin failures++; $display("FAIL fetch_done got=%b exp=00", {bus_req, if_ack}); end
  endtask
  task automatic test_conflict;
    cyc;
    if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h8000_0000;
    #2;
    checks++; if ({bus_req, st_if, st_mem} !== 3'b011) begin failures++; $display("FAIL conf_req got=%b exp=011", {bus_req, st_if, st_mem}); end
    cyc;
    bus_ack = 1; bus_rdata = 32'h0000_00D0;
    #2;
    checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h8000_0000}) begin failures++; $display("FAIL conf_first got=%h exp=180000000", {bus_req, bus_addr}); end
    checks++; if ({d_ack, if_ack, st_if, st_mem} !== 4'b1010 || if_rdata !== 32'h0 || d_rdata !== 32'hD0) begin failures++; $display("FAIL conf_dack got=%b %h %h exp=1010 0 d0", {d_ack, if_ack, st_if, st_mem}, if_rdata, d_rdata); end
    cyc;
    bus_ack = 0; d_req = 0;
    #2;
    checks++; if ({bus_req, st_if} !== 2'b01) begin failures++; $display("FAIL conf_bubble got=%b exp=01", {bus_req, st_if}); end
    cyc;
    bus_ack = 1; bus_rdata = 32'h11;
    #2;
    checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h104}) begin failures++; $display("FAIL conf_second got=%h exp=100000104", {bus_req, bus_addr}); end
    checks++; if ({if_ack, d_ack} !== 2'b10 || if_rdata !== 32'h11) begin failures++; $display("FAIL conf_iack got=%b %h exp=10 11", {if_ack, d_ack}, if_rdata); end
    cyc;
    bus_ack = 0; if_req = 0;
  endtask
  task automatic test_write;
    cyc;
    d_req = 1; d_we = 1; d_sel = 4'b0011; d_addr = 32'h8000_0010; d_wdata = 32'hDEAD_BEEF; bus_rdata = 32'h5555_5555;
    #2;
    checks++; if ({bus_req, st_mem} !== 2'b01) begin failures++; $display("FAIL wr_req got=%b exp=01", {bus_req, st_mem}); end
    for (int i = 1; i <= 5; i++) begin
      cyc;
      bus_ack = (i == 5);
      #2;
      checks++; if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h8000_0010, 32'hDEAD_BEEF}) begin failures++; $display("FAIL wr_fields%0d got=%h", i, {bus_req, bus_we, bus_sel, bus_addr, bus_wdata}); end
      checks++; if ({d_ack, st_mem} !== {i == 5, i != 5} || d_rdata !== ((i == 5) ? 32'h5555_5555 : 32'h0)) begin failures++; $display("FAIL wr_ack%0d got=%b %h", i, {d_ack, st_mem}, d_rdata); end
    end
    cyc;
    d_req = 0; d_we = 0; bus_ack = 1;
    #2;
    checks++; if ({bus_req, d_ack, if_ack} !== 3'b000 || d_rdata !== 32'h0) begin failures++; $display("FAIL stray_ack got=%b %h exp=000 0", {bus_req, d_ack, if_ack}, d_rdata); end
    cyc;
    bus_ack = 0;
    #2;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL stray_idle got=%b exp=0", bus_req); end
  endtask
  task automatic test_flush;
    cyc;
    if_req = 1; if_addr = 32'h180;
    cyc;
    flush = 1; if_req = 0;
    #2;
    checks++; if ({bus_req, if_ack} !== 2'b10) begin failures++; $display("FAIL fl_busy got=%b exp=10", {bus_req, if_ack}); end
    cyc;
    flush = 0;
    #2;
    checks++; if ({bus_req, if_ack} !== 2'b10) begin failures++; $display("FAIL fl_drain got=%b exp=10", {bus_req, if_ack}); end
    cyc;
    bus_ack = 1; bus_rdata = 32'hAAAA;
    #2;
    checks++; if ({bus_req, if_ack} !== 2'b10 || if_rdata !== 32'h0) begin failures++; $display("FAIL fl_drain_ack got=%b %h exp=10 0", {bus_req, if_ack}, if_rdata); end
    cyc;
    bus_ack = 0; if_req = 1; if_addr = 32'h200;
    #2;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL fl_idle got=%b exp=0", bus_req); end
    cyc;
    bus_ack = 1; bus_rdata = 32'h0200_0013;
    #2;
    checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h200} || if_ack !== 1'b1 || if_rdata !== 32'h0200_0013) begin failures++; $display("FAIL fl_refetch got=%h %b %h", {bus_req, bus_addr}, if_ack, if_rdata); end
    cyc;
    bus_ack = 0; if_addr = 32'h240;
    cyc;
    flush = 1; bus_ack = 1;
    #2;
    checks++; if ({bus_req, if_ack} !== 2'b10) begin failures++; $display("FAIL fl_ack_busy got=%b exp=10", {bus_req, if_ack}); end
    cyc;
    flush = 0; bus_ack = 0; if_req = 0;
    #2;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL fl_ack_idle got=%b exp=0", bus_req); end
    if_req = 1; flush = 1;
    cyc;
    if_req = 0; flush = 0;
    #2;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL fl_idle_block got=%b exp=0", bus_req); end
    d_req = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h8000_0030;
    cyc;
    flush = 1; bus_ack = 1; bus_rdata = 32'h77;
    #2;
    checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h77) begin failures++; $display("FAIL fl_dbusy got=%b %h exp=1 77", d_ack, d_rdata); end
    cyc;
    flush = 0; bus_ack = 0; d_req = 0;
  endtask
  task automatic test_reset_mid;
    cyc;
    d_req = 1; d_we = 1; d_sel = 4'hF; d_addr = 32'h8000_0020; d_wdata = 32'h1234;
    cyc;
    #2;
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rm_busy got=%b exp=1", bus_req); end
    rst = 1; d_req = 0; d_we = 0;
    #1;
    checks++; if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata} !== 70'd0 || {d_ack, if_ack, st_mem, st_if} !== 4'd0) begin failures++; $display("FAIL rm_async got=%h %b", {bus_req, bus_we, bus_sel, bus_addr, bus_wdata}, {d_ack, if_ack, st_mem, st_if}); end
    cyc;
    cyc;
    rst = 0;
    #2;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rm_idle got=%b exp=0", bus_req); end
    d_req = 1; d_sel = 4'hF; d_addr = 32'h44;
    cyc;
    bus_ack = 1; bus_rdata = 32'hCAFE;
    #2;
    checks++; if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h44} || d_ack !== 1'b1 || d_rdata !== 32'hCAFE) begin failures++; $display("FAIL rm_new got=%h %b %h", {bus_req, bus_we, bus_addr}, d_ack, d_rdata); end
    cyc;
    bus_ack = 0; d_req = 0;
    #2;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rm_done got=%b exp=0", bus_req); end
  endtask
`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    cyc;
    if_req = 1; if_addr = 32'h300; bus_rdata = 32'h9999;
    for (int i = 1; i <= 8; i++) begin
      cyc;
      #2;
      checks++; if ({bus_req, terr, if_ack} !== {1'b1, i == 8, i == 8}) begin failures++; $display("FAIL to_cycle%0d got=%b", i, {bus_req, terr, if_ack}); end
      if (i == 8) begin
        checks++; if (if_rdata !== 32'h0) begin failures++; $display("FAIL to_rdata got=%h exp=0", if_rdata); end
      end
    end
    cyc;
    if_req = 0;
    #2;
    checks++; if ({bus_req, terr} !== 2'b00) begin failures++; $display("FAIL to_after got=%b exp=00", {bus_req, terr}); end
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_fetch;
    test_conflict;
    test_write;
    test_flush;
    test_reset_mid;
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
